ram_bus_responder: RTL

// - Memory-side responder for the cpu_v RAM bus. Services the CPU's bus_RAM_ADDRESS, bus_RAM_DATA_IN and wire_RW, and returns bus_RAM_DATA_OUT.
// - Single-port word RAM. Fixed 1-cycle read latency, matching the CPU's staged load/store/loadi/storei sequencing.
// - Optional zero-clear sweep after reset. Out-of-range fault flag and write counter are provided for debug.

---
 rtl/cpu_v_bus_pkg.sv | 16 +
 rtl/ram_bus_responder_ram_array.sv | 31 +++
 rtl/ram_bus_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_v_bus_pkg.sv
// Shared definitions for the cpu_v RAM bus: bus widths, read/write encoding
// and the responder state type.
package cpu_v_bus_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 16;
  localparam int unsigned BUS_ADDR_WIDTH = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic {
    ST_CLEAR,
    ST_SERVE
  } resp_state_t;

endpackage

// File: rtl/ram_bus_responder_ram_array.sv
// Synchronous single-port write-first RAM.
// Ports:
//   clk_i   - rising-edge clock
//   we_i    - write enable
//   addr_i  - word index
//   wdata_i - write data
//   rdata_o - registered read data; on a write it takes wdata_i
module ram_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 32768,
  parameter int unsigned AW         = 15
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_o     <= wdata_i;
    end else begin
      rdata_o     <= mem[addr_i];
    end
  end

endmodule

// File: rtl/ram_bus_responder.sv
// Memory-side responder for the cpu_v RAM bus: single-port word RAM with a
// one-cycle read latency, optional zero-clear sweep after reset, an
// out-of-range fault pulse and a saturating write counter.
// Ports:
//   wire_clock       - rising-edge clock
//   wire_reset       - asynchronous active-high reset
//   bus_RAM_ADDRESS  - word address from CPU
//   bus_RAM_DATA_IN  - write data from CPU
//   wire_RW          - 1 = write, 0 = read
//   bus_RAM_DATA_OUT - registered read data (write-first)
//   wire_ready       - 1 while servicing the bus
//   wire_addr_fault  - 1-cycle pulse on an access at or beyond DEPTH
//   bus_write_count  - accepted writes since reset, saturating
module ram_bus_responder
  import cpu_v_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int unsigned DEPTH          = 32768,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  wire_clock,
  input  logic                  wire_reset,
  input  logic [ADDR_WIDTH-1:0] bus_RAM_ADDRESS,
  input  logic [DATA_WIDTH-1:0] bus_RAM_DATA_IN,
  input  logic                  wire_RW,
  output logic [DATA_WIDTH-1:0] bus_RAM_DATA_OUT,
  output logic                  wire_ready,
  output logic                  wire_addr_fault,
  output logic [15:0]           bus_write_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  resp_state_t           state_q, state_d;
  logic [AW-1:0]         clear_ptr_q, clear_ptr_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic                  valid_q, valid_d;
  logic [15:0]           wcnt_q, wcnt_d;

  logic                  port_we;
  logic [AW-1:0]         port_addr;
  logic [DATA_WIDTH-1:0] port_wdata;
  logic [DATA_WIDTH-1:0] port_rdata;
  logic                  in_range;

  // Full-width compare; only the low AW bits index the array.
  assign in_range = ({1'b0, bus_RAM_ADDRESS} < DEPTH_W);

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    fault_d     = 1'b0;
    valid_d     = 1'b0;
    wcnt_d      = wcnt_q;
    port_we     = 1'b0;
    port_addr   = bus_RAM_ADDRESS[AW-1:0];
    port_wdata  = bus_RAM_DATA_IN;
    unique case (state_q)
      ST_CLEAR: begin
        port_we     = 1'b1;
        port_addr   = clear_ptr_q;
        port_wdata  = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_PTR) begin
          state_d = ST_SERVE;
          ready_d = 1'b1;
        end
      end
      ST_SERVE: begin
        ready_d = 1'b1;
        if (in_range) begin
          valid_d = 1'b1;
          if (wire_RW == RW_WRITE) begin
            port_we = 1'b1;
            if (wcnt_q != '1) wcnt_d = wcnt_q + 16'd1;
          end
        end else begin
          fault_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      valid_q     <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      valid_q     <= valid_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // The RAM output register has no reset; masking it with valid_q gives the
  // async zero on reset, zero during the sweep and zero after a faulting access.
  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk_i   (wire_clock),
    .we_i    (port_we & ~wire_reset),
    .addr_i  (port_addr),
    .wdata_i (port_wdata),
    .rdata_o (port_rdata)
  );

  assign bus_RAM_DATA_OUT = port_rdata & {DATA_WIDTH{valid_q}};
  assign wire_ready       = ready_q;
  assign wire_addr_fault  = fault_q;
  assign bus_write_count  = wcnt_q;

endmodule
